ldlt_stream: RTL
================

Name: ldlt_stream

Overview:
- Parametrised fixed-point LDLᵀ factoriser for a symmetric N×N matrix.
- Accepts the lower triangle as a valid/ready stream, factors it in place, and streams back the packed result: D on the diagonal, unit-lower L below it.
- Next generation of the team's dense LDLT block:
  - matrix order is a parameter;
  - full handshakes on both sides;
  - a shared multi-cycle divider replaces combinational division;
  - quotients saturate, and the block flags zero pivots.

Parameters:
- DATA_LEN, 34, signed word width, two's complement.
- FRACTION, 16, fractional bits (Q format).
- MAT_N, 6, matrix order N, range 2..64.
- IDX_W, 6, counter width; must satisfy 2^IDX_W ≥ MAT_N+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_start  in  1  start pulse; accepted only in IDLE.
- i_valid  in  1  input word valid.
- o_ready  out  1  block accepts an input word.
- i_data  in  DATA_LEN  input word.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts an output word.
- o_data  out  DATA_LEN  output word.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after the last output word is accepted.
- o_err_pivot  out  1  sticky: a zero pivot was seen in the current run.
- o_err_sat  out  1  sticky: a quotient saturated in the current run.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; counters 0. Matrix storage is not cleared.
- Reset mid-operation: return to IDLE on the next edge and drop any in-flight divide. o_done does not pulse.
- Stream order, both directions: lower triangle, column-major. For j = 0..N-1, for i = j..N-1: element (i,j). Total W = N(N+1)/2 words.
- States: IDLE → READ → PROC → WRTE → IDLE.
- IDLE:
  - i_start=1 clears both error flags and moves to READ.
  - i_start is ignored in every other state.
- READ:
  - o_ready=1.
  - A word transfers on i_valid & o_ready.
  - After the W-th transfer, o_ready drops in the same cycle and the state moves to PROC.
- PROC, for i = 1..N-1 and j = 0..i-1:
  - MAC phase, k = 0..j-1, one cycle each:
    - m1 = (A[i][k]·A[k][k]) >>> F
    - m2 = (m1·A[j][k]) >>> F
    - A[i][j] −= m2
    - Products are 2·DATA_LEN wide; the result is truncated to DATA_LEN.
  - Division phase:
    - Divide 1: q = (A[i][j] <<< F) / A[j][j].
    - Divide 2: r = (A[i][j]·A[i][j]) / A[j][j], using the pre-update A[i][j].
    - Then A[i][i] −= r and A[i][j] ← sat(q), written in the same cycle.
  - Division rules:
    - Signed, truncated toward zero.
    - A result outside the DATA_LEN range saturates to max/min and sets o_err_sat.
    - A[j][j]==0 forces both results to 0, sets o_err_pivot, and processing continues.
  - PROC → WRTE after pair (N-1, N-2) completes.
- WRTE:
  - o_valid=1 with o_data holding the current word.
  - o_data is stable while o_valid & !i_ready.
  - Advance on i_ready.
  - After the W-th accepted word: o_done pulses and the state returns to IDLE.
- Storage: register array of W entries, addressed by (i,j); multiple combinational reads; at most two writes per cycle.
- Divider: fixed latency DIV_CYC = DATA_LEN+FRACTION+1 cycles from start to done, with one operation in flight at a time.

Decomposition:
- Package ldlt_pkg holds:
  - state encoding constants;
  - a triangular-index function idx(i,j) = j·N − j(j−1)/2 + (i−j);
  - saturation limits derived from DATA_LEN.
- Sub-module ldlt_div_seq: restoring radix-2 signed divider.
  - Inputs: start, numerator (2·DATA_LEN), denominator (DATA_LEN).
  - Outputs: done, saturated quotient (DATA_LEN), sat, div0.

Test Plan:
- Basic factorisation:
  - Stimulus: N=2, F=16, A=[[4,2],[2,5]], stream 262144, 131072, 327680, with i_ready=1.
  - Response: output 262144, 32768, 262144; o_done pulses once; both error flags stay 0.
- Zero pivot:
  - Stimulus: N=2, A00=0, A10=65536, A11=65536.
  - Response: output 0, 0, 65536; o_err_pivot=1; o_err_sat=0.
- Saturation:
  - Stimulus: N=2, A00=1, A10=1048576, A11=0.
  - Response: L10=2^33−1; o_err_sat=1.
- Backpressure:
  - Stimulus: N=3, identity·65536, with i_ready toggled 1,0,0,1… and gaps in i_valid.
  - Response: the 6 outputs are 65536, 0, 0, 65536, 0, 65536; o_data is stable while stalled; no word is lost or duplicated.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for one cycle mid-PROC, then run a new i_start with the basic-factorisation data.
  - Response: all outputs are 0 the cycle after reset; o_done does not pulse for the aborted run; the rerun gives the basic-factorisation results.
- Start during operation:
  - Stimulus: pulse i_start during READ and during WRTE.
  - Response: ignored; sequence and outputs unchanged.

Source files
------------

// File: rtl/ldlt_pkg.sv
// Shared types and helpers for the streaming LDL^T factoriser.
package ldlt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_PROC = 2'd2,
    S_WRTE = 2'd3
  } state_t;

  // Sub-steps of one (i,j) pair while in S_PROC.
  typedef enum logic [1:0] {
    PH_MAC  = 2'd0,
    PH_DIV1 = 2'd1,
    PH_DIV2 = 2'd2
  } phase_t;

  // Lower-triangle, column-major linear address of element (i,j), i >= j.
  function automatic int idx(input int n, input int i, input int j);
    return j * n - (j * (j - 1)) / 2 + (i - j);
  endfunction

  function automatic logic [127:0] sat_pos(input int dl);
    return (128'(1) << (dl - 1)) - 128'(1);
  endfunction

  function automatic logic [127:0] sat_neg(input int dl);
    return ~sat_pos(dl);
  endfunction

endpackage

// File: rtl/ldlt_div_seq.sv
// Restoring radix-2 signed divider, fixed latency, saturating quotient.
module ldlt_div_seq #(
  parameter int DATA_LEN = 34,
  parameter int FRACTION = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [2*DATA_LEN-1:0]   num_i,
  input  logic [DATA_LEN-1:0]     den_i,
  output logic                    done_o,
  output logic [DATA_LEN-1:0]     quo_o,
  output logic                    sat_o,
  output logic                    div0_o
);
  import ldlt_pkg::*;

  localparam int NW      = 2 * DATA_LEN;
  localparam int DIV_CYC = DATA_LEN + FRACTION + 1;
  localparam int ITER    = DIV_CYC - 1;
  localparam int CW      = $clog2(ITER + 1);
  localparam logic [DATA_LEN-1:0] QMAX = DATA_LEN'(sat_pos(DATA_LEN));
  localparam logic [DATA_LEN-1:0] QMIN = DATA_LEN'(sat_neg(DATA_LEN));
  localparam logic [ITER-1:0]     LIM  = ITER'(1) << (DATA_LEN - 1);

  logic [NW-1:0]              num_abs;
  logic [DATA_LEN-1:0]        den_abs;
  logic [DATA_LEN-FRACTION-1:0] num_hi;
  logic                       ovf_d;

  logic [DATA_LEN-1:0]        rem_q, den_q;
  logic [ITER-1:0]            sh_q;
  logic [CW-1:0]              cnt_q;
  logic                       busy_q, done_q, neg_q, ovf_q, div0_q;
  logic [DATA_LEN:0]          trial;
  logic                       ge;

  assign num_abs = num_i[NW-1] ? -num_i : num_i;
  assign den_abs = den_i[DATA_LEN-1] ? -den_i : den_i;
  // Bits above ITER only matter for overflow: if they already reach the
  // divisor the quotient is >= 2^ITER, far past saturation.
  assign num_hi  = num_abs[NW-1:ITER];
  assign ovf_d   = {{FRACTION{1'b0}}, num_hi} >= den_abs;

  assign trial = {rem_q, sh_q[ITER-1]};
  assign ge    = trial >= {1'b0, den_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= {{FRACTION{1'b0}}, num_hi};
        den_q  <= den_abs;
        sh_q   <= num_abs[ITER-1:0];
        cnt_q  <= CW'(ITER);
        busy_q <= 1'b1;
        neg_q  <= num_i[NW-1] ^ den_i[DATA_LEN-1];
        ovf_q  <= ovf_d;
        div0_q <= (den_i == '0);
      end else if (busy_q) begin
        rem_q <= ge ? DATA_LEN'(trial - {1'b0, den_q}) : trial[DATA_LEN-1:0];
        sh_q  <= {sh_q[ITER-2:0], ge};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    quo_o = '0;
    sat_o = 1'b0;
    if (div0_q) begin
      quo_o = '0;
    end else if (neg_q) begin
      if (ovf_q || sh_q > LIM) begin
        quo_o = QMIN;
        sat_o = 1'b1;
      end else begin
        quo_o = -sh_q[DATA_LEN-1:0];
      end
    end else begin
      if (ovf_q || sh_q >= LIM) begin
        quo_o = QMAX;
        sat_o = 1'b1;
      end else begin
        quo_o = sh_q[DATA_LEN-1:0];
      end
    end
  end

  assign done_o = done_q;
  assign div0_o = div0_q;

endmodule

// File: rtl/ldlt_stream.sv
// Streaming in-place LDL^T factoriser: lower triangle in, packed D/L out.
module ldlt_stream #(
  parameter int DATA_LEN = 34,
  parameter int FRACTION = 16,
  parameter int MAT_N    = 6,
  parameter int IDX_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DATA_LEN-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_pivot,
  output logic                o_err_sat
);
  import ldlt_pkg::*;

  localparam int W  = MAT_N * (MAT_N + 1) / 2;
  localparam int AW = $clog2(W);
  localparam int PW = 2 * DATA_LEN;
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(MAT_N - 1);
  localparam logic [IDX_W-1:0] PENULT = IDX_W'(MAT_N - 2);
  localparam logic [AW-1:0]    WLAST  = AW'(W - 1);

  state_t state_q, state_d;
  phase_t phase_q, phase_d;

  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic [AW-1:0]    ptr_q;
  logic signed [DATA_LEN-1:0] mem_q [W];
  logic signed [DATA_LEN-1:0] q_q;
  logic done_q, err_piv_q, err_sat_q;

  logic [AW-1:0] ad_ij, ad_jj, ad_ii, ad_ik, ad_kk, ad_jk;
  logic signed [DATA_LEN-1:0] a_ij, a_jj, a_ii, a_ik, a_kk, a_jk, m1, m2;
  logic signed [PW-1:0] p1, p2, num1, num2;

  logic                div_start, div_done, div_sat, div_div0;
  logic [DATA_LEN-1:0] div_quo;
  logic                mac_we, upd_we;

  assign ad_ij = AW'(idx(MAT_N, int'(i_q), int'(j_q)));
  assign ad_jj = AW'(idx(MAT_N, int'(j_q), int'(j_q)));
  assign ad_ii = AW'(idx(MAT_N, int'(i_q), int'(i_q)));
  assign ad_ik = AW'(idx(MAT_N, int'(i_q), int'(k_q)));
  assign ad_kk = AW'(idx(MAT_N, int'(k_q), int'(k_q)));
  assign ad_jk = AW'(idx(MAT_N, int'(j_q), int'(k_q)));

  assign a_ij = mem_q[ad_ij];
  assign a_jj = mem_q[ad_jj];
  assign a_ii = mem_q[ad_ii];
  assign a_ik = mem_q[ad_ik];
  assign a_kk = mem_q[ad_kk];
  assign a_jk = mem_q[ad_jk];

  // MAC term L_ik * D_k * L_jk, each product rescaled back to Q format.
  assign p1 = PW'(a_ik) * PW'(a_kk);
  assign m1 = DATA_LEN'(p1 >>> FRACTION);
  assign p2 = PW'(m1) * PW'(a_jk);
  assign m2 = DATA_LEN'(p2 >>> FRACTION);

  assign num1 = PW'(a_ij) <<< FRACTION;
  assign num2 = PW'(a_ij) * PW'(a_ij);

  ldlt_div_seq #(
    .DATA_LEN (DATA_LEN),
    .FRACTION (FRACTION)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .num_i   ((phase_q == PH_MAC) ? num1 : num2),
    .den_i   (a_jj),
    .done_o  (div_done),
    .quo_o   (div_quo),
    .sat_o   (div_sat),
    .div0_o  (div_div0)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    div_start = 1'b0;
    mac_we    = 1'b0;
    upd_we    = 1'b0;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_READ;
      S_READ: begin
        o_ready = 1'b1;
        if (i_valid && ptr_q == WLAST) begin
          state_d = S_PROC;
          phase_d = PH_MAC;
        end
      end
      S_PROC: begin
        case (phase_q)
          PH_MAC: begin
            if (k_q != j_q) begin
              mac_we = 1'b1;
            end else begin
              div_start = 1'b1;
              phase_d   = PH_DIV1;
            end
          end
          // Second divide still sees the pre-update A[i][j]; q is parked in q_q.
          PH_DIV1: if (div_done) begin
            div_start = 1'b1;
            phase_d   = PH_DIV2;
          end
          PH_DIV2: if (div_done) begin
            upd_we  = 1'b1;
            phase_d = PH_MAC;
            if (i_q == LAST && j_q == PENULT) state_d = S_WRTE;
          end
          default: phase_d = PH_MAC;
        endcase
      end
      S_WRTE: begin
        o_valid = 1'b1;
        if (i_ready && ptr_q == WLAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_MAC;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ptr_q     <= '0;
      q_q       <= '0;
      done_q    <= 1'b0;
      err_piv_q <= 1'b0;
      err_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (i_start) begin
          err_piv_q <= 1'b0;
          err_sat_q <= 1'b0;
          ptr_q     <= '0;
        end
        S_READ: if (i_valid) begin
          if (ptr_q == WLAST) begin
            ptr_q <= '0;
            i_q   <= IDX_W'(1);
            j_q   <= '0;
            k_q   <= '0;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        S_PROC: begin
          if (mac_we) k_q <= k_q + IDX_W'(1);
          if (div_done) begin
            err_piv_q <= err_piv_q | div_div0;
            err_sat_q <= err_sat_q | div_sat;
          end
          if (phase_q == PH_DIV1 && div_done) q_q <= div_quo;
          if (upd_we) begin
            k_q <= '0;
            if (j_q + IDX_W'(1) == i_q) begin
              i_q <= i_q + IDX_W'(1);
              j_q <= '0;
            end else begin
              j_q <= j_q + IDX_W'(1);
            end
          end
        end
        S_WRTE: if (i_ready) begin
          if (ptr_q == WLAST) begin
            ptr_q  <= '0;
            done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state_q == S_READ && i_valid) mem_q[ptr_q] <= i_data;
    if (mac_we) mem_q[ad_ij] <= a_ij - m2;
    if (upd_we) begin
      mem_q[ad_ij] <= q_q;
      mem_q[ad_ii] <= a_ii - div_quo;
    end
  end

  assign o_data      = (state_q == S_WRTE) ? mem_q[ptr_q] : '0;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_err_pivot = err_piv_q;
  assign o_err_sat   = err_sat_q;

endmodule
